// File: rtl/fx_writeback_queue.sv
// Writeback queue for the fixed-point unit: buffers FX results (GPR write plus optional
// CR/XER side write) and drains them one write at a time to the register-file port.
module fx_writeback_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned addrWidth  = 6,
    parameter int unsigned dataWidth  = 64,
    parameter logic [1:0]  FXUnitCode = 2'd0
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [1:0]                   functionalUnitCode_i,
    input  logic                         reg1WritebackEnable_i,
    input  logic [addrWidth-1:0]         reg1WritebackAddress_i,
    input  logic [dataWidth-1:0]         reg1WritebackVal_i,
    input  logic                         reg2WritebackEnable_i,
    input  logic [addrWidth-1:0]         reg2WritebackAddress_i,
    input  logic [dataWidth-1:0]         reg2WritebackVal_i,
    output logic                         full_o,
    output logic                         wbValid_o,
    output logic                         wbIsSide_o,
    output logic [addrWidth-1:0]         wbAddress_o,
    output logic [dataWidth-1:0]         wbVal_o,
    input  logic                         wbReady_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                 en1;
        logic [addrWidth-1:0] addr1;
        logic [dataWidth-1:0] val1;
        logic                 en2;
        logic [addrWidth-1:0] addr2;
        logic [dataWidth-1:0] val2;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND1 = 2'd1,
        SEND2 = 2'd2
    } state_t;

    entry_t               r_mem [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic                 r_overflow;
    state_t               r_state;
    logic                 r_wb_valid;
    logic                 r_wb_side;
    logic [addrWidth-1:0] r_wb_addr;
    logic [dataWidth-1:0] r_wb_val;

    logic                 w_push;
    logic                 w_store;
    logic                 w_pop;
    logic                 w_load;
    entry_t               w_in_entry;
    entry_t               w_head;
    entry_t               w_next;
    entry_t               w_load_entry;
    logic [CNT_W-1:0]     w_count_nxt;

    assign w_push = (functionalUnitCode_i == FXUnitCode)
                  & (reg1WritebackEnable_i | reg2WritebackEnable_i);
    // Admission is judged against the registered full flag; a same-cycle pop never frees a slot.
    assign w_store = w_push & ~r_full;

    assign w_in_entry = '{
        en1:   reg1WritebackEnable_i,
        addr1: reg1WritebackAddress_i,
        val1:  reg1WritebackVal_i,
        en2:   reg2WritebackEnable_i,
        addr2: reg2WritebackAddress_i,
        val2:  reg2WritebackVal_i
    };

    assign w_head = r_mem[r_head];
    assign w_next = r_mem[PTR_W'(r_head + PTR_W'(1))];

    // An entry retires on acceptance of its last write.
    assign w_pop = wbReady_i & (((r_state == SEND1) & ~w_head.en2) | (r_state == SEND2));

    // Start a new entry from idle, or chain straight into the following entry after a pop.
    // Only entries stored before this edge are eligible, so a fresh push never bypasses.
    assign w_load = ((r_state == IDLE) & (r_count != '0))
                  | (w_pop & (r_count > CNT_W'(1)));
    assign w_load_entry = (r_state == IDLE) ? w_head : w_next;

    assign w_count_nxt = r_count + CNT_W'(w_store) - CNT_W'(w_pop);

    always_ff @(posedge clock_i) begin
        if (w_store) begin
            r_mem[r_tail] <= w_in_entry;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_state    <= IDLE;
            r_wb_valid <= 1'b0;
            r_wb_side  <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_val   <= '0;
        end else begin
            if (w_store) begin
                r_tail <= PTR_W'(r_tail + PTR_W'(1));
            end
            if (w_push & r_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_head <= PTR_W'(r_head + PTR_W'(1));
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));

            if (w_load) begin
                r_state    <= w_load_entry.en1 ? SEND1 : SEND2;
                r_wb_valid <= 1'b1;
                r_wb_side  <= ~w_load_entry.en1;
                r_wb_addr  <= w_load_entry.en1 ? w_load_entry.addr1 : w_load_entry.addr2;
                r_wb_val   <= w_load_entry.en1 ? w_load_entry.val1 : w_load_entry.val2;
            end else if (w_pop) begin
                r_state    <= IDLE;
                r_wb_valid <= 1'b0;
            end else if ((r_state == SEND1) & wbReady_i) begin
                r_state    <= SEND2;
                r_wb_side  <= 1'b1;
                r_wb_addr  <= w_head.addr2;
                r_wb_val   <= w_head.val2;
            end else if ((r_state != IDLE) & (r_state != SEND1) & (r_state != SEND2)) begin
                r_state    <= IDLE;
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign full_o      = r_full;
    assign overflow_o  = r_overflow;
    assign count_o     = r_count;
    assign wbValid_o   = r_wb_valid;
    assign wbIsSide_o  = r_wb_side;
    assign wbAddress_o = r_wb_addr;
    assign wbVal_o     = r_wb_val;

endmodule

// File: tb/tb_fx_writeback_queue.sv
// Bench for fx_writeback_queue: directed scenarios plus random traffic against a
// transaction-level model (queue of expected writes, entry count, full and overflow flags).
module tb_fx_writeback_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 64;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic [1:0]    functionalUnitCode_i;
    logic          reg1WritebackEnable_i;
    logic [AW-1:0] reg1WritebackAddress_i;
    logic [DW-1:0] reg1WritebackVal_i;
    logic          reg2WritebackEnable_i;
    logic [AW-1:0] reg2WritebackAddress_i;
    logic [DW-1:0] reg2WritebackVal_i;
    logic          full_o;
    logic          wbValid_o;
    logic          wbIsSide_o;
    logic [AW-1:0] wbAddress_o;
    logic [DW-1:0] wbVal_o;
    logic          wbReady_i;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    fx_writeback_queue #(
        .DEPTH(DEPTH), .addrWidth(AW), .dataWidth(DW), .FXUnitCode(2'd0)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .functionalUnitCode_i(functionalUnitCode_i),
        .reg1WritebackEnable_i(reg1WritebackEnable_i),
        .reg1WritebackAddress_i(reg1WritebackAddress_i),
        .reg1WritebackVal_i(reg1WritebackVal_i),
        .reg2WritebackEnable_i(reg2WritebackEnable_i),
        .reg2WritebackAddress_i(reg2WritebackAddress_i),
        .reg2WritebackVal_i(reg2WritebackVal_i),
        .full_o(full_o),
        .wbValid_o(wbValid_o),
        .wbIsSide_o(wbIsSide_o),
        .wbAddress_o(wbAddress_o),
        .wbVal_o(wbVal_o),
        .wbReady_i(wbReady_i),
        .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        bit            side;
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
        bit            last;
        int            ptick;
    } wr_t;

    wr_t exp_q[$];
    int  m_count;
    bit  m_full;
    bit  m_ovf;
    int  tick_no;
    int  n_cmp;
    int  n_err;
    int  n_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_push(input logic [1:0] unit, input bit e1, input logic [AW-1:0] a1,
                            input logic [DW-1:0] v1, input bit e2, input logic [AW-1:0] a2,
                            input logic [DW-1:0] v2);
        functionalUnitCode_i   = unit;
        reg1WritebackEnable_i  = e1;
        reg1WritebackAddress_i = a1;
        reg1WritebackVal_i     = v1;
        reg2WritebackEnable_i  = e2;
        reg2WritebackAddress_i = a2;
        reg2WritebackVal_i     = v2;
    endtask

    task automatic clr_push();
        set_push(2'd0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // One clock: advance the model with the values present at the edge, then check the DUT.
    task automatic tick();
        bit  rst;
        bit  acc;
        bit  push;
        bit  p_valid;
        bit  p_ready;
        wr_t w;
        tick_no++;
        rst     = reset_i;
        p_valid = wbValid_o;
        p_ready = wbReady_i;
        acc     = wbValid_o && wbReady_i;
        push    = (functionalUnitCode_i == 2'd0) && (reg1WritebackEnable_i || reg2WritebackEnable_i);
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_full  = 0;
            m_ovf   = 0;
        end else begin
            if (acc) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_write", 64'(wbValid_o), 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    n_acc++;
                    if (w.last) m_count--;
                end
            end
            if (push) begin
                if (m_full) begin
                    m_ovf = 1;
                end else begin
                    if (reg1WritebackEnable_i)
                        exp_q.push_back('{0, reg1WritebackAddress_i, reg1WritebackVal_i,
                                          !reg2WritebackEnable_i, tick_no});
                    if (reg2WritebackEnable_i)
                        exp_q.push_back('{1, reg2WritebackAddress_i, reg2WritebackVal_i,
                                          1'b1, tick_no});
                    m_count++;
                end
            end
            m_full = (m_count == DEPTH);
        end

        @(posedge clock_i);
        #1;

        check_eq("count", 64'(count_o), 64'(m_count));
        check_eq("full", 64'(full_o), 64'(m_full));
        check_eq("overflow", 64'(overflow_o), 64'(m_ovf));
        if (rst) begin
            check_eq("valid_after_reset", 64'(wbValid_o), 64'd0);
        end else if (p_valid && !p_ready) begin
            check_eq("valid_held", 64'(wbValid_o), 64'd1);
        end
        if (wbValid_o) begin
            if (exp_q.size() == 0) begin
                check_eq("valid_when_empty", 64'(wbValid_o), 64'd0);
            end else begin
                check_eq("wb_side", 64'(wbIsSide_o), 64'(exp_q[0].side));
                check_eq("wb_addr", 64'(wbAddress_o), 64'(exp_q[0].addr));
                check_eq("wb_val", wbVal_o, exp_q[0].val);
                check_eq("no_bypass", 64'(exp_q[0].ptick < tick_no), 64'd1);
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        clr_push();
        wbReady_i = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_acc = 0; tick_no = 0;
        m_count = 0; m_full = 0; m_ovf = 0;
        wbReady_i = 1'b0;
        clr_push();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        check_eq("reset_count", 64'(count_o), 64'd0);
        check_eq("reset_full", 64'(full_o), 64'd0);
        check_eq("reset_valid", 64'(wbValid_o), 64'd0);

        // single GPR write
        wbReady_i = 1'b1;
        set_push(2'd0, 1'b1, 6'd5, 64'h1234, 1'b0, '0, '0);
        tick();
        clr_push();
        tick();
        check_eq("t1_valid", 64'(wbValid_o), 64'd1);
        check_eq("t1_side", 64'(wbIsSide_o), 64'd0);
        check_eq("t1_addr", 64'(wbAddress_o), 64'd5);
        check_eq("t1_val", wbVal_o, 64'h1234);
        tick();
        check_eq("t1_count", 64'(count_o), 64'd0);

        // dual write: GPR then side write on consecutive cycles
        set_push(2'd0, 1'b1, 6'd3, 64'hA, 1'b1, 6'd32, 64'h1);
        tick();
        clr_push();
        tick();
        check_eq("t2_side0", 64'(wbIsSide_o), 64'd0);
        check_eq("t2_addr0", 64'(wbAddress_o), 64'd3);
        tick();
        check_eq("t2_valid1", 64'(wbValid_o), 64'd1);
        check_eq("t2_side1", 64'(wbIsSide_o), 64'd1);
        check_eq("t2_addr1", 64'(wbAddress_o), 64'd32);
        check_eq("t2_val1", wbVal_o, 64'h1);
        tick();
        check_eq("t2_count", 64'(count_o), 64'd0);

        // fill, overflow, drain in order
        wbReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push(2'd0, 1'b1, 6'(i + 8), 64'(100 + i), 1'b0, '0, '0);
            tick();
        end
        clr_push();
        check_eq("t3_full", 64'(full_o), 64'd1);
        check_eq("t3_count", 64'(count_o), 64'd4);
        set_push(2'd0, 1'b1, 6'd63, 64'd999, 1'b0, '0, '0);
        tick();
        check_eq("t3_overflow", 64'(overflow_o), 64'd1);
        check_eq("t3_count_held", 64'(count_o), 64'd4);
        n_acc = 0;
        drain(20);
        check_eq("t3_drained", 64'(n_acc), 64'd4);

        // concurrent push/pop keeps count, order across wrap
        do_reset();
        wbReady_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(2'd0, 1'b1, 6'(i), 64'(200 + i), 1'b0, '0, '0);
            tick();
        end
        wbReady_i = 1'b1;
        set_push(2'd0, 1'b1, 6'd3, 64'd203, 1'b0, '0, '0);
        tick();
        check_eq("t4_count_steady", 64'(count_o), 64'd3);
        for (int i = 4; i < 10; i++) begin
            set_push(2'd0, 1'b1, 6'(i), 64'(200 + i), 1'b0, '0, '0);
            tick();
        end
        drain(30);

        // foreign unit code and empty entries are ignored
        for (int i = 0; i < 4; i++) begin
            if (i < 2) set_push(2'(i + 1), 1'b1, 6'(i), 64'(300 + i), 1'b1, 6'(i), 64'd7);
            else       set_push(2'd0, 1'b0, 6'(i), 64'(300 + i), 1'b0, 6'(i), 64'd7);
            tick();
            check_eq("t5_no_valid", 64'(wbValid_o), 64'd0);
            check_eq("t5_no_count", 64'(count_o), 64'd0);
        end

        // long stall then reset mid-drain
        wbReady_i = 1'b0;
        set_push(2'd0, 1'b1, 6'd11, 64'hDEAD, 1'b1, 6'd12, 64'hBEEF);
        tick();
        set_push(2'd0, 1'b1, 6'd13, 64'hCAFE, 1'b0, '0, '0);
        tick();
        clr_push();
        for (int i = 0; i < 5; i++) tick();
        check_eq("t6_stall_valid", 64'(wbValid_o), 64'd1);
        check_eq("t6_stall_addr", 64'(wbAddress_o), 64'd11);
        wbReady_i = 1'b1;
        do_reset();
        check_eq("t6_rst_valid", 64'(wbValid_o), 64'd0);
        check_eq("t6_rst_count", 64'(count_o), 64'd0);
        check_eq("t6_rst_full", 64'(full_o), 64'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            set_push(($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                     1'($urandom_range(0, 1)), 6'($urandom), {$urandom, $urandom},
                     1'($urandom_range(0, 1)), 6'($urandom), {$urandom, $urandom});
            wbReady_i = ($urandom_range(0, 9) < 6);
            reset_i   = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset_i = 1'b0;
        drain(40);
        check_eq("final_count", 64'(count_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
